reg_release_buffer: RTL and testbench

//  Commit-side producer for the physical-register freelist push port. It collects stale

---
 rtl/reg_release_buffer_pkg.sv | 29 ++
 rtl/reg_release_buffer_if.sv | 25 ++
 rtl/reg_release_buffer_lane_compact.sv | 29 ++
 rtl/reg_release_buffer.sv | 87 ++++++++
 tb/tb_reg_release_buffer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/reg_release_buffer_pkg.sv
// Shared parameters and types for the commit-side register release buffer.
// Core sizing is common with the rename/freelist path; buffer depth is local to this block.
package reg_release_buffer_pkg;

  localparam int unsigned DISPATCH_WIDTH       = 2;
  localparam int unsigned PHYS_REGS            = 64;
  localparam int unsigned PHYS_REGS_ADDR_WIDTH = 6;
  localparam int unsigned RELEASE_BUF_DEPTH    = 8;

  localparam int unsigned BUF_PTR_W  = $clog2(RELEASE_BUF_DEPTH);
  localparam int unsigned BUF_CNT_W  = BUF_PTR_W + 1;
  localparam int unsigned LANE_CNT_W = $clog2(DISPATCH_WIDTH + 1);
  localparam int unsigned ROOM_W     = PHYS_REGS_ADDR_WIDTH + 2;

  typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] preg_t;
  typedef logic [DISPATCH_WIDTH-1:0]       lane_mask_t;
  typedef preg_t [DISPATCH_WIDTH-1:0]      preg_lanes_t;

  // Thermometer mask with the low n lanes set.
  function automatic lane_mask_t lane_mask(input logic [LANE_CNT_W-1:0] n);
    lane_mask_t m;
    m = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      m[i] = (LANE_CNT_W'(i) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/reg_release_buffer_if.sv
// Commit-in / freelist-push-out bundle of the register release buffer.
// master drives commits and the freelist free count; slave is the buffer.
interface reg_release_buffer_if;
  import reg_release_buffer_pkg::*;

  lane_mask_t                      commit_en;
  preg_lanes_t                     commit_preg;
  logic                            commit_ready;
  logic [PHYS_REGS_ADDR_WIDTH:0]   num_free;
  lane_mask_t                      push_en;
  preg_lanes_t                     push_reg;
  logic [BUF_CNT_W-1:0]            occupancy;
  logic                            drop_err;

  modport master (
    output commit_en, commit_preg, num_free,
    input  commit_ready, push_en, push_reg, occupancy, drop_err
  );

  modport slave (
    input  commit_en, commit_preg, num_free,
    output commit_ready, push_en, push_reg, occupancy, drop_err
  );

endinterface

// File: rtl/reg_release_buffer_lane_compact.sv
// Combinational lane compactor: packs valid lanes to the low slots in lane order
// and reports how many were valid. Unused output slots read as zero.
module reg_release_buffer_lane_compact #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 6
) (
  input  logic [N-1:0]              valid,
  input  logic [N-1:0][W-1:0]       data_in,
  output logic [N-1:0][W-1:0]       data_out,
  output logic [$clog2(N+1)-1:0]    count
);

  localparam int unsigned CW = $clog2(N + 1);

  // Each valid lane lands in the slot equal to the number of valid lanes before it.
  always_comb begin
    data_out = '0;
    count    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (valid[i]) begin
        for (int unsigned j = 0; j < N; j++) begin
          if (CW'(j) == count) data_out[j] = data_in[i];
        end
        count = count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/reg_release_buffer.sv
// Buffers stale physical registers released at commit and drains them into the
// freelist push lanes in strict FIFO order, never pushing past freelist capacity.
module reg_release_buffer
  import reg_release_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  reg_release_buffer_if.slave  bus
);

  logic [BUF_PTR_W-1:0]  head_q, tail_q;
  logic [BUF_CNT_W-1:0]  count_q;
  logic                  drop_q;
  preg_t                 buf_q [RELEASE_BUF_DEPTH];

  lane_mask_t            lane_valid;
  preg_lanes_t           packed_preg;
  logic [LANE_CNT_W-1:0] n_valid, n_in, n_drain;
  logic [ROOM_W-1:0]     room;
  logic                  overflow;

  // Register 0 is hardwired x0 and never returns to the freelist.
  always_comb begin
    lane_valid = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      lane_valid[i] = bus.commit_en[i] && (bus.commit_preg[i] != '0);
    end
  end

  reg_release_buffer_lane_compact #(
    .N (DISPATCH_WIDTH),
    .W (PHYS_REGS_ADDR_WIDTH)
  ) u_lane_compact (
    .valid    (lane_valid),
    .data_in  (bus.commit_preg),
    .data_out (packed_preg),
    .count    (n_valid)
  );

  assign bus.commit_ready = (BUF_CNT_W'(RELEASE_BUF_DEPTH) - count_q) >= BUF_CNT_W'(DISPATCH_WIDTH);
  assign n_in             = bus.commit_ready ? n_valid : '0;
  assign overflow         = (|bus.commit_en) && !bus.commit_ready;

  // Freelist headroom, clamped at zero if num_free ever reports above capacity.
  always_comb begin
    if (ROOM_W'(bus.num_free) >= ROOM_W'(PHYS_REGS)) room = '0;
    else                                             room = ROOM_W'(PHYS_REGS) - ROOM_W'(bus.num_free);
  end

  always_comb begin
    n_drain = LANE_CNT_W'(DISPATCH_WIDTH);
    if (ROOM_W'(n_drain) > room)       n_drain = LANE_CNT_W'(room);
    if (BUF_CNT_W'(n_drain) > count_q) n_drain = LANE_CNT_W'(count_q);
  end

  always_comb begin
    bus.push_en = lane_mask(n_drain);
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      bus.push_reg[i] = buf_q[BUF_PTR_W'(head_q + BUF_PTR_W'(i))];
    end
  end

  assign bus.occupancy = count_q;
  assign bus.drop_err  = drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      head_q  <= head_q + BUF_PTR_W'(n_drain);
      tail_q  <= tail_q + BUF_PTR_W'(n_in);
      count_q <= count_q + BUF_CNT_W'(n_in) - BUF_CNT_W'(n_drain);
      if (overflow) drop_q <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      if (LANE_CNT_W'(i) < n_in) buf_q[BUF_PTR_W'(tail_q + BUF_PTR_W'(i))] <= packed_preg[i];
    end
  end

endmodule

// File: tb/tb_reg_release_buffer.sv
// Self-checking bench for reg_release_buffer: a queue scoreboard of expected pushes
// plus scenario tasks with their own directed checks.
module tb_reg_release_buffer;
  import reg_release_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_release_buffer_if bus();

  reg_release_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_pass  = 0;
  int    n_total = 0;
  preg_t sb_q[$];
  logic  sb_drop = 1'b0;

  // One cycle: drive inputs, compare outputs against the scoreboard, advance the model.
  task automatic tick(input logic [1:0] en, input preg_t p1, input preg_t p0, input logic [6:0] nf);
    int         exp_n;
    int         room;
    logic [1:0] exp_en;
    logic       ready;
    bus.commit_en      = en;
    bus.commit_preg[1] = p1;
    bus.commit_preg[0] = p0;
    bus.num_free       = nf;
    #1;
    room  = (int'(nf) >= 64) ? 0 : 64 - int'(nf);
    exp_n = sb_q.size();
    if (exp_n > 2) exp_n = 2;
    if (room < exp_n) exp_n = room;
    exp_en = (exp_n == 2) ? 2'b11 : (exp_n == 1) ? 2'b01 : 2'b00;
    ready  = (8 - sb_q.size()) >= 2;

    n_total++;
    if (bus.push_en !== exp_en) $display("FAIL sb_push_en: got %b expected %b", bus.push_en, exp_en);
    else n_pass++;
    for (int i = 0; i < exp_n; i++) begin
      n_total++;
      if (bus.push_reg[i] !== sb_q[i]) $display("FAIL sb_push_reg[%0d]: got %0d expected %0d", i, bus.push_reg[i], sb_q[i]);
      else n_pass++;
    end
    n_total++;
    if (int'(bus.occupancy) !== sb_q.size()) $display("FAIL sb_occupancy: got %0d expected %0d", bus.occupancy, sb_q.size());
    else n_pass++;
    n_total++;
    if (bus.commit_ready !== ready) $display("FAIL sb_commit_ready: got %b expected %b", bus.commit_ready, ready);
    else n_pass++;
    n_total++;
    if (bus.drop_err !== sb_drop) $display("FAIL sb_drop_err: got %b expected %b", bus.drop_err, sb_drop);
    else n_pass++;

    repeat (exp_n) void'(sb_q.pop_front());
    if (ready) begin
      if (en[0] && p0 != 0) sb_q.push_back(p0);
      if (en[1] && p1 != 0) sb_q.push_back(p1);
    end else if (en != 2'b00) begin
      sb_drop = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n            = 1'b0;
    bus.commit_en    = 2'b00;
    bus.commit_preg  = '0;
    bus.num_free     = 7'd40;
    repeat (2) @(negedge clk);
    n_total++;
    if (bus.push_en !== 2'b00) $display("FAIL reset_push_en: got %b expected 00", bus.push_en); else n_pass++;
    n_total++;
    if (bus.occupancy !== 4'd0) $display("FAIL reset_occupancy: got %0d expected 0", bus.occupancy); else n_pass++;
    n_total++;
    if (bus.commit_ready !== 1'b1) $display("FAIL reset_commit_ready: got %b expected 1", bus.commit_ready); else n_pass++;
    n_total++;
    if (bus.drop_err !== 1'b0) $display("FAIL reset_drop_err: got %b expected 0", bus.drop_err); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pair;
    tick(2'b11, 6'd9, 6'd5, 7'd40);
    n_total++;
    if (bus.push_en !== 2'b11 || bus.push_reg[0] !== 6'd5 || bus.push_reg[1] !== 6'd9)
      $display("FAIL pair_push: got en=%b r0=%0d r1=%0d expected en=11 r0=5 r1=9", bus.push_en, bus.push_reg[0], bus.push_reg[1]);
    else n_pass++;
    tick(2'b00, 6'd0, 6'd0, 7'd40);
    n_total++;
    if (bus.occupancy !== 4'd0) $display("FAIL pair_drained: got %0d expected 0", bus.occupancy); else n_pass++;
  endtask

  task automatic test_zero_lane;
    tick(2'b10, 6'd7, 6'd0, 7'd40);
    n_total++;
    if (bus.push_en !== 2'b01 || bus.push_reg[0] !== 6'd7)
      $display("FAIL zero_first: got en=%b r0=%0d expected en=01 r0=7", bus.push_en, bus.push_reg[0]);
    else n_pass++;
    tick(2'b11, 6'd0, 6'd3, 7'd40);
    n_total++;
    if (bus.push_en !== 2'b01 || bus.push_reg[0] !== 6'd3)
      $display("FAIL zero_skip: got en=%b r0=%0d expected en=01 r0=3", bus.push_en, bus.push_reg[0]);
    else n_pass++;
    tick(2'b00, 6'd0, 6'd0, 7'd40);
    n_total++;
    if (bus.occupancy !== 4'd0) $display("FAIL zero_drained: got %0d expected 0", bus.occupancy); else n_pass++;
  endtask

  task automatic test_freelist_full;
    tick(2'b11, 6'd21, 6'd20, 7'd64);
    bus.num_free = 7'd63;
    #1;
    n_total++;
    if (bus.push_en !== 2'b01) $display("FAIL fl_one_room: got %b expected 01", bus.push_en); else n_pass++;
    tick(2'b00, 6'd0, 6'd0, 7'd63);
    bus.num_free = 7'd64;
    #1;
    n_total++;
    if (bus.push_en !== 2'b00) $display("FAIL fl_full_hold: got %b expected 00", bus.push_en); else n_pass++;
    repeat (2) tick(2'b00, 6'd0, 6'd0, 7'd64);
    n_total++;
    if (bus.occupancy !== 4'd1) $display("FAIL fl_occupancy: got %0d expected 1", bus.occupancy); else n_pass++;
    repeat (2) tick(2'b00, 6'd0, 6'd0, 7'd40);
  endtask

  task automatic test_overflow;
    for (int k = 0; k < 4; k++) tick(2'b11, preg_t'(11 + 2*k), preg_t'(10 + 2*k), 7'd64);
    n_total++;
    if (bus.occupancy !== 4'd8 || bus.commit_ready !== 1'b0)
      $display("FAIL ovf_full: got occ=%0d ready=%b expected occ=8 ready=0", bus.occupancy, bus.commit_ready);
    else n_pass++;
    tick(2'b11, 6'd50, 6'd51, 7'd64);
    n_total++;
    if (bus.drop_err !== 1'b1 || bus.occupancy !== 4'd8)
      $display("FAIL ovf_drop: got drop=%b occ=%0d expected drop=1 occ=8", bus.drop_err, bus.occupancy);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    tick(2'b11, 6'd30, 6'd31, 7'd40);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.push_en !== 2'b00 || bus.occupancy !== 4'd0 || bus.commit_ready !== 1'b1 || bus.drop_err !== 1'b0)
      $display("FAIL mid_reset: got en=%b occ=%0d ready=%b drop=%b expected en=00 occ=0 ready=1 drop=0",
               bus.push_en, bus.occupancy, bus.commit_ready, bus.drop_err);
    else n_pass++;
    sb_q.delete();
    sb_drop       = 1'b0;
    bus.commit_en = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 20; c++) begin
      tick(2'b11, preg_t'(2*c + 2), preg_t'(2*c + 1), 7'd0);
      n_total++;
      if (bus.occupancy > 4'd2) $display("FAIL b2b_bound: got %0d expected <= 2", bus.occupancy); else n_pass++;
    end
    repeat (3) tick(2'b00, 6'd0, 6'd0, 7'd0);
    n_total++;
    if (sb_q.size() != 0 || bus.occupancy !== 4'd0)
      $display("FAIL b2b_drained: got occ=%0d pending=%0d expected 0", bus.occupancy, sb_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pair();
    test_zero_lane();
    test_freelist_full();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
